// File: rtl/tick_scheduler.sv
// tick_scheduler: one shared prescaler feeding four independent tick channels.
// Each channel counts base ticks up to its programmed period and emits a
// single-cycle TICK strobe (periodic or one-shot). TICK/BUSY are clock enables.

// One timing channel: period/mode registers, base-tick counter, IDLE/RUN state.
module tick_chan #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          base_tick,
  input  logic          cfg_wr,
  input  logic [PW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          cfg_en,
  output logic          tick,
  output logic          busy
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next-state: a config write always wins and restarts from cnt=0;
  // otherwise a running channel advances once per base tick.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (cfg_wr) begin
      period_d = cfg_period;
      mode_d   = cfg_mode;
      cnt_d    = '0;
      state_d  = (cfg_en && (cfg_period != '0)) ? RUN : IDLE;
    end else if (state_q == RUN && base_tick) begin
      if (cnt_q == period_q - PW'(1)) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        if (mode_q) state_d = IDLE;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Channel registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  // A write accepted this cycle cancels a strobe registered on the previous
  // base tick, so a stop issued on the completing base tick (and stalled one
  // cycle by the handshake) still suppresses that pulse.
  assign tick = tick_q & ~cfg_wr;
  assign busy = (state_q == RUN);
endmodule

module tick_scheduler #(
  parameter int PRESCALE = 100000,
  parameter int PW       = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [1:0]    CFG_CH,
  input  logic [PW-1:0] CFG_PERIOD,
  input  logic          CFG_MODE,
  input  logic          CFG_EN,
  output logic          BASE_TICK,
  output logic [3:0]    TICK,
  output logic [3:0]    BUSY
);
  localparam int NUM_CH = 4;
  localparam int CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PMAX = CW'(PRESCALE - 1);

  logic [CW-1:0]     pcnt_q, pcnt_d;
  logic              cfg_acc;
  logic [NUM_CH-1:0] ch_wr;

  assign BASE_TICK = (pcnt_q == PMAX);
  // Writes are refused on base-tick cycles so a config never races a count step.
  assign CFG_READY = ~BASE_TICK;
  assign cfg_acc   = CFG_VALID & CFG_READY;

  // Prescaler wraps after PRESCALE cycles.
  always_comb begin
    pcnt_d = BASE_TICK ? '0 : pcnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  // Route an accepted write to the addressed channel only.
  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_wr[i] = cfg_acc && (CFG_CH == 2'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(.PW(PW)) u_ch (
      .clk        (CLK),
      .rst        (RST),
      .base_tick  (BASE_TICK),
      .cfg_wr     (ch_wr[g]),
      .cfg_period (CFG_PERIOD),
      .cfg_mode   (CFG_MODE),
      .cfg_en     (CFG_EN),
      .tick       (TICK[g]),
      .busy       (BUSY[g])
    );
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios with tabulated expectations
// plus constrained-random config traffic against a closed-form reference.
module tb_tick_scheduler;
  localparam int P  = 4;
  localparam int PW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CFG_VALID = 1'b0;
  logic [1:0]    CFG_CH = 2'd0;
  logic [PW-1:0] CFG_PERIOD = '0;
  logic          CFG_MODE = 1'b0;
  logic          CFG_EN = 1'b0;
  logic          CFG_READY, BASE_TICK;
  logic [3:0]    TICK, BUSY;

  tick_scheduler #(.PRESCALE(P), .PW(PW)) dut (
    .CLK(CLK), .RST(RST), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH), .CFG_PERIOD(CFG_PERIOD), .CFG_MODE(CFG_MODE), .CFG_EN(CFG_EN),
    .BASE_TICK(BASE_TICK), .TICK(TICK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: per channel, the accepted config and the cycle it was accepted.
  bit m_act[4];
  int m_p[4];
  bit m_m[4];
  int m_a[4];

  logic [3:0] o_tick[64];
  logic [3:0] o_busy[64];
  logic       o_bt[64];
  logic       o_rdy[64];

  typedef struct {
    int         c;
    logic [3:0] tick;
    logic [3:0] busy;
    logic       bt;
    logic       rdy;
  } vec_t;

  // Number of base-tick cycles in [0, x] since reset release.
  function automatic int nb(int x);
    return (x + 1) / P;
  endfunction

  function automatic bit isbt(int x);
    return (x % P) == P - 1;
  endfunction

  // TICK at t: previous cycle was a base tick and the base ticks seen since
  // acceptance reach a positive multiple of the period (exactly once if one-shot).
  function automatic bit exp_tick(int c, int t);
    int n;
    if (!m_act[c] || (t - 1) <= m_a[c] || !isbt(t - 1)) return 1'b0;
    n = nb(t - 1) - nb(m_a[c]);
    return (n > 0) && (n % m_p[c] == 0) && (!m_m[c] || n == m_p[c]);
  endfunction

  function automatic bit exp_busy(int c, int t);
    int n;
    if (!m_act[c]) return 1'b0;
    n = nb(t - 1) - nb(m_a[c]);
    return !m_m[c] || (n < m_p[c]);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      m_act[c] = 1'b0; m_p[c] = 0; m_m[c] = 1'b0; m_a[c] = 0;
    end
  endtask

  // Drive one cycle's request, sample mid-cycle, compare to the reference, advance.
  task automatic step(input logic v, input logic [1:0] ch, input logic [PW-1:0] per,
                      input logic md, input logic en);
    logic [3:0] et, eb;
    bit acc;
    CFG_VALID = v; CFG_CH = ch; CFG_PERIOD = per; CFG_MODE = md; CFG_EN = en;
    #4;
    acc = v && !isbt(cyc);
    for (int c = 0; c < 4; c++) begin
      et[c] = exp_tick(c, cyc);
      eb[c] = exp_busy(c, cyc);
    end
    if (acc) et[ch] = 1'b0;
    chk("base_tick", 32'(BASE_TICK), 32'(isbt(cyc)));
    chk("cfg_ready", 32'(CFG_READY), 32'(!isbt(cyc)));
    chk("tick", 32'(TICK), 32'(et));
    chk("busy", 32'(BUSY), 32'(eb));
    if (cyc < 64) begin
      o_tick[cyc] = TICK; o_busy[cyc] = BUSY; o_bt[cyc] = BASE_TICK; o_rdy[cyc] = CFG_READY;
    end
    if (acc) begin
      m_act[ch] = en && (per != '0);
      m_p[ch]   = int'(per);
      m_m[ch]   = md;
      m_a[ch]   = cyc;
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, '0, 1'b0, 1'b0);
  endtask

  // Hold reset two cycles, check reset outputs, release at the start of cycle 0.
  task automatic do_reset();
    RST = 1'b1;
    CFG_VALID = 1'b0; CFG_CH = 2'd0; CFG_PERIOD = '0; CFG_MODE = 1'b0; CFG_EN = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst_tick", 32'(TICK), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_base_tick", 32'(BASE_TICK), 32'h0);
    chk("rst_ready", 32'(CFG_READY), 32'h1);
    RST = 1'b0;
    cyc = 0;
    clear_model();
  endtask

  vec_t tbl[10];
  int   cnt, cnt2;
  logic hv, hmd, hen;
  logic [1:0] hch;
  logic [PW-1:0] hper;
  bit   stalled;

  initial begin
    // CH0 period 3 periodic, written in cycle 0.
    tbl[0] = '{0,  4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[1] = '{1,  4'b0000, 4'b0001, 1'b0, 1'b1};
    tbl[2] = '{3,  4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[3] = '{11, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[4] = '{12, 4'b0001, 4'b0001, 1'b0, 1'b1};
    tbl[5] = '{13, 4'b0000, 4'b0001, 1'b0, 1'b1};
    tbl[6] = '{23, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[7] = '{24, 4'b0001, 4'b0001, 1'b0, 1'b1};
    tbl[8] = '{35, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[9] = '{36, 4'b0001, 4'b0001, 1'b0, 1'b1};

    @(posedge CLK); #1;

    // Periodic channel, table-checked.
    do_reset();
    step(1'b1, 2'd0, 8'd3, 1'b0, 1'b1);
    idle(40);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_tick", i), 32'(o_tick[tbl[i].c]), 32'(tbl[i].tick));
      chk($sformatf("tbl%0d_busy", i), 32'(o_busy[tbl[i].c]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_bt", i),   32'(o_bt[tbl[i].c]),   32'(tbl[i].bt));
      chk($sformatf("tbl%0d_rdy", i),  32'(o_rdy[tbl[i].c]),  32'(tbl[i].rdy));
    end

    // One-shot CH1 alongside periodic CH2.
    do_reset();
    step(1'b1, 2'd1, 8'd2, 1'b1, 1'b1);
    step(1'b1, 2'd2, 8'd1, 1'b0, 1'b1);
    idle(40);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 42; i++) begin
      if (o_tick[i][1]) cnt++;
      if (o_tick[i][1] && o_tick[i][2]) cnt2++;
    end
    chk("oneshot_count", 32'(cnt), 32'd1);
    chk("coincide_count", 32'(cnt2), 32'd1);
    chk("oneshot_tick8", 32'(o_tick[8]), 32'h6);
    chk("oneshot_busy7", 32'(o_busy[7][1]), 32'h1);
    chk("oneshot_busy8", 32'(o_busy[8][1]), 32'h0);
    chk("ch2_tick12", 32'(o_tick[12][2]), 32'h1);

    // Handshake stall: request raised on a base-tick cycle.
    do_reset();
    idle(3);
    step(1'b1, 2'd3, 8'd1, 1'b0, 1'b1);
    step(1'b1, 2'd3, 8'd1, 1'b0, 1'b1);
    idle(10);
    chk("stall_ready3", 32'(o_rdy[3]), 32'h0);
    chk("stall_busy4", 32'(o_busy[4][3]), 32'h0);
    chk("stall_busy5", 32'(o_busy[5][3]), 32'h1);
    chk("stall_tick8", 32'(o_tick[8][3]), 32'h1);

    // Stop on the completing base tick, then period=0 with EN=1.
    do_reset();
    step(1'b1, 2'd0, 8'd3, 1'b0, 1'b1);
    idle(10);
    step(1'b1, 2'd0, 8'd3, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'd3, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 2'd0, 8'd0, 1'b0, 1'b1);
    idle(20);
    cnt = 0;
    for (int i = 0; i < 35; i++) if (o_tick[i][0]) cnt++;
    chk("stop_tick_count", 32'(cnt), 32'd0);
    chk("stop_busy13", 32'(o_busy[13][0]), 32'h0);
    chk("zero_period_busy20", 32'(o_busy[20][0]), 32'h0);

    // Asynchronous reset pulse mid-run.
    do_reset();
    step(1'b1, 2'd0, 8'd1, 1'b0, 1'b1);
    idle(2);
    #1;
    chk("pre_rst_busy", 32'(BUSY), 32'h1);
    chk("pre_rst_bt", 32'(BASE_TICK), 32'h1);
    RST = 1'b1;
    #1;
    chk("async_busy", 32'(BUSY), 32'h0);
    chk("async_tick", 32'(TICK), 32'h0);
    chk("async_bt", 32'(BASE_TICK), 32'h0);
    chk("async_ready", 32'(CFG_READY), 32'h1);
    RST = 1'b0;
    cyc = 0;
    clear_model();
    idle(30);
    cnt = 0;
    for (int i = 0; i < 30; i++) if (o_tick[i] != 4'b0000) cnt++;
    chk("post_rst_tick_count", 32'(cnt), 32'd0);

    // Randomized traffic; stalled requests are held until accepted.
    do_reset();
    stalled = 1'b0;
    hv = 1'b0; hch = 2'd0; hper = '0; hmd = 1'b0; hen = 1'b0;
    repeat (800) begin
      if (!stalled) begin
        hv   = ($urandom_range(3) == 0);
        hch  = 2'($urandom_range(3));
        hper = ($urandom_range(9) == 0) ? 8'd255 : PW'($urandom_range(6));
        hmd  = 1'($urandom_range(1));
        hen  = ($urandom_range(4) != 0);
      end
      stalled = hv && isbt(cyc);
      step(hv, hch, hper, hmd, hen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
